// File: rtl/ucsbece152a_input_conditioner.sv
// ----------------------------------------------------------------------------
// ucsbece152a_input_conditioner
//
// Purpose:
//   Front end for the counter / seven-segment top. Each raw push button is
//   synchronized, debounced and edge-detected. A run/pause FSM gates a tick
//   prescaler that produces a one-cycle count-enable pulse every TICK_DIV
//   cycles. The direction button toggles a direction level.
//
// Parameters:
//   SYNC_STAGES     synchronizer depth per button (>= 2)
//   DEBOUNCE_CYCLES consecutive differing cycles before a debounced value flips
//   TICK_DIV        clock cycles per enable_o pulse while running (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   btn_run_i  in   raw run/pause button (asynchronous)
//   btn_dir_i  in   raw direction button (asynchronous)
//   btn_step_i in   raw single-step button (only with STEP_MODE_EN)
//   enable_o   out  registered one-cycle count enable
//   dir_o      out  registered direction level, 1 = up, 0 = down
//   running_o  out  high while the FSM is in RUNNING
//
// Optional feature:
//   Define STEP_MODE_EN to add btn_step_i: a step press while paused issues
//   exactly one enable_o pulse.
// ----------------------------------------------------------------------------

// Per-button conditioning: synchronizer -> debouncer -> rising-edge detect.
module ucsbece152a_input_conditioner_btn #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic                   r_stable_d;
    logic [CW-1:0]          r_count;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        // NOTE: every flop here uses <= so the chain shifts one stage per
        // edge; blocking assignments would collapse the synchronizer.
        if (rst) begin
            r_sync     <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_count    <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_stable_d <= r_stable;
            if (w_sync == r_stable) begin
                // Any agreement restarts the qualification window.
                r_count <= '0;
            end else if (r_count == DB_LAST) begin
                r_stable <= w_sync;
                r_count  <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Only the debounced rising edge counts; release is silent.
    assign o_press = r_stable & ~r_stable_d;
endmodule

module ucsbece152a_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run_i,
    input  logic btn_dir_i,
`ifdef STEP_MODE_EN
    input  logic btn_step_i,
`endif
    output logic enable_o,
    output logic dir_o,
    output logic running_o
);
    // Keep the prescaler at least one bit wide so TICK_DIV == 1 is legal.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          w_run_press;
    logic          w_dir_press;
    logic          w_step_press;
    logic          w_terminal;

    ucsbece152a_input_conditioner_btn #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_run (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (btn_run_i),
        .o_press(w_run_press)
    );

    ucsbece152a_input_conditioner_btn #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_dir (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (btn_dir_i),
        .o_press(w_dir_press)
    );

`ifdef STEP_MODE_EN
    ucsbece152a_input_conditioner_btn #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_step (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (btn_step_i),
        .o_press(w_step_press)
    );
`else
    assign w_step_press = 1'b0;
`endif

    assign w_terminal = (r_state == RUNNING) && (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        // NOTE: reset clears the synchronizers and debouncers as well, so a
        // button held across reset release must qualify again from scratch.
        if (rst) begin
            r_state   <= PAUSED;
            running_o <= 1'b0;
            enable_o  <= 1'b0;
            dir_o     <= 1'b1;
            r_presc   <= '0;
        end else begin
            // A run press on the terminal count pauses without a pulse; a
            // step press only acts while paused and loses to a run press.
            enable_o <= (w_terminal && !w_run_press) ||
                        ((r_state == PAUSED) && w_step_press && !w_run_press);

            if (w_run_press) begin
                r_state   <= (r_state == RUNNING) ? PAUSED : RUNNING;
                running_o <= (r_state == PAUSED);
                r_presc   <= '0;
            end else if (r_state == RUNNING) begin
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            end else begin
                r_presc <= '0;
            end

            // Toggles on the same edge as enable_o, so a coincident tick
            // steps the counter in the new direction.
            if (w_dir_press) begin
                dir_o <= ~dir_o;
            end
        end
    end
endmodule

// File: tb/tb_ucsbece152a_input_conditioner.sv
module tb_ucsbece152a_input_conditioner;
    localparam int S  = 2;
    localparam int DC = 4;
    localparam int TD = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_run_i = 1'b0;
    logic btn_dir_i = 1'b0;
`ifdef STEP_MODE_EN
    logic btn_step_i = 1'b0;
`endif
    logic enable_o;
    logic dir_o;
    logic running_o;

    always #5 clk = ~clk;

    ucsbece152a_input_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(DC),
        .TICK_DIV       (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run_i (btn_run_i),
        .btn_dir_i (btn_dir_i),
`ifdef STEP_MODE_EN
        .btn_step_i(btn_step_i),
`endif
        .enable_o  (enable_o),
        .dir_o     (dir_o),
        .running_o (running_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (spec-level) ----------------
    // Buttons: 0 = run, 1 = dir, 2 = step. The synchronizer is a pure delay of
    // the raw history; a debounced value flips once the last DC synchronized
    // samples all disagree with it. The tick is derived from the number of
    // edges elapsed since entering RUNNING.
    bit raw_q  [3][$];
    bit sync_q [3][$];
    bit m_stable   [3];
    bit m_stable_d [3];
    bit m_running = 1'b0;
    bit m_dir     = 1'b1;
    bit m_en      = 1'b0;
    int m_entry   = 0;
    int cyc       = 0;

    task automatic model_edge(input logic r, input logic [2:0] raw);
        logic [2:0] press;
        if (r) begin
            for (int b = 0; b < 3; b++) begin
                raw_q[b].delete();
                sync_q[b].delete();
                raw_q[b].push_back(1'b0);
                m_stable[b]   = 1'b0;
                m_stable_d[b] = 1'b0;
            end
            m_running = 1'b0;
            m_dir     = 1'b1;
            m_en      = 1'b0;
            return;
        end
        for (int b = 0; b < 3; b++) press[b] = m_stable[b] & ~m_stable_d[b];
        for (int b = 0; b < 3; b++) begin
            bit s;
            bit all_diff;
            raw_q[b].push_back(raw[b]);
            s = (raw_q[b].size() > S) ? raw_q[b][raw_q[b].size() - 1 - S] : 1'b0;
            sync_q[b].push_back(s);
            m_stable_d[b] = m_stable[b];
            if (sync_q[b].size() >= DC) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DC; k++)
                    if (sync_q[b][sync_q[b].size() - k] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
            while (raw_q[b].size() > 32) void'(raw_q[b].pop_front());
            while (sync_q[b].size() > 32) void'(sync_q[b].pop_front());
        end
        m_en = m_running && !press[0] && (((cyc - m_entry) % TD) == 0);
`ifdef STEP_MODE_EN
        if (!m_running && press[2] && !press[0]) m_en = 1'b1;
`endif
        if (press[0]) begin
            m_running = !m_running;
            if (m_running) m_entry = cyc;
        end
        if (press[1]) m_dir = !m_dir;
    endtask

    bit step_raw = 1'b0;

    // One clock: drive at the falling edge, model the rising edge, compare
    // at the next falling edge.
    task automatic step(input logic run, input logic dir, input logic r);
        rst       = r;
        btn_run_i = run;
        btn_dir_i = dir;
`ifdef STEP_MODE_EN
        btn_step_i = step_raw;
`endif
        @(posedge clk);
        cyc++;
        model_edge(r, {step_raw, dir, run});
        @(negedge clk);
        check("enable_o", enable_o, m_en);
        check("dir_o", dir_o, m_dir);
        check("running_o", running_o, m_running);
    endtask

    task automatic press_btn(input bit is_dir);
        for (int i = 0; i < 8; i++) step(!is_dir, is_dir, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        int toggles;
        bit prev;
        int last_en;
        int press_edge;
        int rise_cyc;
        int first_en;
        logic rr;
        logic rd;

        // 1. reset and idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("rst_enable", enable_o, 0);
        check("rst_dir", dir_o, 1);
        check("rst_running", running_o, 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (enable_o) cnt++;
        end
        check("idle_pulses", cnt, 0);

        // 2. bouncy run press, then tick rate
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        toggles = 0;
        prev = running_o;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (running_o != prev) toggles++;
            prev = running_o;
        end
        check("run_toggles", toggles, 1);
        check("run_on", running_o, 1);
        cnt = 0;
        toggles = 0;
        prev = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (enable_o) cnt++;
            if (enable_o && prev) toggles++;
            prev = enable_o;
        end
        check("pulses_in_50", cnt, 10);
        check("double_pulses", toggles, 0);

        // 3. direction presses while running, spacing stays 5
        last_en = -1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b0, i < 8, 1'b0);
                if (enable_o) begin
                    if (last_en >= 0) check("spacing", cyc - last_en, TD);
                    last_en = cyc;
                end
            end
            check("dir_after_press", dir_o, (p == 0) ? 0 : 1);
        end

        // 4. run press landing on the terminal count
        for (int i = 0; i < TD && ((cyc + 1 + S + DC - m_entry) % TD) != 0; i++)
            step(1'b0, 1'b0, 1'b0);
        press_edge = cyc + 1 + S + DC;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (cyc == press_edge) check("pause_no_pulse", enable_o, 0);
        end
        check("paused", running_o, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (enable_o) cnt++;
        end
        check("paused_pulses", cnt, 0);
        rise_cyc = -1;
        first_en = -1;
        for (int i = 0; i < 30; i++) begin
            step(i < 8, 1'b0, 1'b0);
            if (running_o && rise_cyc < 0) rise_cyc = cyc;
            if (enable_o && first_en < 0) first_en = cyc;
        end
        check("restart_first_pulse", first_en - rise_cyc, TD);

        // 5. reset mid-run with dir_o = 0, run held through release
        if (dir_o) press_btn(1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("midrst_enable", enable_o, 0);
        check("midrst_dir", dir_o, 1);
        check("midrst_running", running_o, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == S + DC) check("held_wait", running_o, 0);
            if (i == S + DC + 1) check("held_press", running_o, 1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);

`ifdef STEP_MODE_EN
        // 6. single step while paused, ignored while running
        if (running_o) press_btn(1'b0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step_raw = (i < 8);
            step(1'b0, 1'b0, 1'b0);
            if (enable_o) cnt++;
        end
        check("step_pulses", cnt, 1);
        press_btn(1'b0);
        for (int i = 0; i < 16; i++) begin
            step_raw = (i < 8);
            step(1'b0, 1'b0, 1'b0);
        end
        step_raw = 1'b0;
`endif

        // Randomized phase: sticky raw levels with occasional bounces/resets.
        rr = 1'b0;
        rd = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) rr = ~rr;
            if ($urandom_range(7) == 0) rd = ~rd;
`ifdef STEP_MODE_EN
            if ($urandom_range(8) == 0) step_raw = ~step_raw;
`endif
            step(rr, rd, $urandom_range(399) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
